control_unit: RTL and testbench

Sequencer for the 8-bit accumulator datapath. It fetches 4-bit opcodes through the IR/PC/ROM path and drives every datapath load and select line. It evaluates the datapath's StopProgram and cout flags for conditional jumps, and halts on a HALT opcode or when an instruction-count watchdog expires. It sits beside the datapath in the CPU top level and is the only source of the datapath's control inputs.

---
 rtl/control_unit_pkg.sv | 30 +++
 rtl/cu_watchdog.sv | 27 ++
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
package control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_JLT  = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/cu_watchdog.sv
// Instruction-count watchdog: counts EXECUTE exits since the last start.
module cu_watchdog #(
  parameter int CNT_W     = 8,
  parameter int MAX_INSTR = 200
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign o_expire  = i_inc && (w_cnt_inc == CNT_W'(MAX_INSTR));

  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencer FSM and control decode for the 8-bit accumulator datapath.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MAX_INSTR = 200,
  parameter int CNT_W     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] IR_CU,
  input  logic       StopProgram,
  input  logic       cout,
  output logic       A_select,
  output logic       Aload,
  output logic       Bload,
  output logic       IRload,
  output logic       PCload,
  output logic       ANSload,
  output logic [1:0] SelectMode,
  output logic       Jump_Sel,
  output logic       Busy,
  output logic       Halted,
  output logic       Timeout
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_mode;
  logic       w_wd_clr;
  logic       w_wd_inc;
  logic       w_expire;
  logic       w_to_set;
  logic       w_to_clr;

  cu_watchdog #(
    .CNT_W    (CNT_W),
    .MAX_INSTR(MAX_INSTR)
  ) u_wd (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_clear (w_wd_clr),
    .i_inc   (w_wd_inc),
    .o_expire(w_expire)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_mode  <= ALU_ADD;
      Timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECUTE && ANSload) begin
        r_mode <= SelectMode;
      end
      if (w_to_set) begin
        Timeout <= 1'b1;
      end else if (w_to_clr) begin
        Timeout <= 1'b0;
      end
    end
  end

  assign Busy   = (r_state == S_FETCH) || (r_state == S_LOAD_IR) ||
                  (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
  assign Halted = (r_state == S_HALT);

  always_comb begin
    w_next     = r_state;
    A_select   = 1'b0;
    Aload      = 1'b0;
    Bload      = 1'b0;
    IRload     = 1'b0;
    PCload     = 1'b0;
    ANSload    = 1'b0;
    SelectMode = ALU_ADD;
    Jump_Sel   = 1'b0;
    w_wd_clr   = 1'b0;
    w_wd_inc   = 1'b0;
    w_to_set   = 1'b0;
    w_to_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next   = S_FETCH;
          w_wd_clr = 1'b1;
        end
      end
      S_FETCH: w_next = S_LOAD_IR;
      S_LOAD_IR: begin
        IRload = 1'b1;
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_wd_inc = 1'b1;
        w_next   = S_FETCH;
        PCload   = 1'b1;
        case (IR_CU)
          OP_LDA: begin
            A_select = 1'b1;
            Aload    = 1'b1;
          end
          OP_LDB: Bload = 1'b1;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ANSload = 1'b1;
            w_next  = S_WRITEBACK;
            case (IR_CU)
              OP_SUB:  SelectMode = ALU_SUB;
              OP_AND:  SelectMode = ALU_AND;
              OP_OR:   SelectMode = ALU_OR;
              default: SelectMode = ALU_ADD;
            endcase
          end
          OP_JMP: Jump_Sel = 1'b1;
          OP_JLT: Jump_Sel = StopProgram;
          OP_JC:  Jump_Sel = cout;
          OP_HALT: begin
            PCload = 1'b0;
            w_next = S_HALT;
          end
          default: ;
        endcase
        // Expiry overrides both WRITEBACK and a normal return to FETCH
        if (w_expire) begin
          w_next   = S_HALT;
          w_to_set = 1'b1;
        end
      end
      S_WRITEBACK: begin
        Aload      = 1'b1;
        SelectMode = r_mode;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        if (Start) begin
          w_next   = S_FETCH;
          w_wd_clr = 1'b1;
          w_to_clr = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small IR/PC/ROM model per instance.
module tb_control_unit;
  import control_unit_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, Start, StopProgram, cout;
  logic [3:0] rom [16];
  logic [3:0] ir_a, pc_a, ir_b, pc_b;

  logic       A_select, Aload, Bload, IRload, PCload, ANSload;
  logic       Jump_Sel, Busy, Halted, Timeout;
  logic [1:0] SelectMode;
  logic       A_select_5, Aload_5, Bload_5, IRload_5, PCload_5, ANSload_5;
  logic       Jump_Sel_5, Busy_5, Halted_5, Timeout_5;
  logic [1:0] SelectMode_5;

  logic [10:0] obs, obs5;
  assign obs  = {IRload, PCload, Aload, A_select, Bload, ANSload,
                 Jump_Sel, SelectMode, Busy, Halted};
  assign obs5 = {IRload_5, PCload_5, Aload_5, A_select_5, Bload_5,
                 ANSload_5, Jump_Sel_5, SelectMode_5, Busy_5, Halted_5};

  int n_chk = 0;
  int n_pass = 0;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR_CU(ir_a),
    .StopProgram(StopProgram), .cout(cout),
    .A_select(A_select), .Aload(Aload), .Bload(Bload),
    .IRload(IRload), .PCload(PCload), .ANSload(ANSload),
    .SelectMode(SelectMode), .Jump_Sel(Jump_Sel),
    .Busy(Busy), .Halted(Halted), .Timeout(Timeout)
  );

  control_unit #(.MAX_INSTR(5), .CNT_W(8)) dut5 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR_CU(ir_b),
    .StopProgram(StopProgram), .cout(cout),
    .A_select(A_select_5), .Aload(Aload_5), .Bload(Bload_5),
    .IRload(IRload_5), .PCload(PCload_5), .ANSload(ANSload_5),
    .SelectMode(SelectMode_5), .Jump_Sel(Jump_Sel_5),
    .Busy(Busy_5), .Halted(Halted_5), .Timeout(Timeout_5)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset) begin
      pc_a <= 4'd0; ir_a <= 4'd0;
      pc_b <= 4'd0; ir_b <= 4'd0;
    end else begin
      if (IRload)   ir_a <= rom[pc_a];
      if (PCload)   pc_a <= Jump_Sel ? 4'd0 : pc_a + 4'd1;
      if (IRload_5) ir_b <= rom[pc_b];
      if (PCload_5) pc_b <= Jump_Sel_5 ? 4'd0 : pc_b + 4'd1;
    end
  end

  localparam logic [10:0] X_F   = 11'b00000000010;
  localparam logic [10:0] X_L   = 11'b10000000010;
  localparam logic [10:0] X_LDA = 11'b01110000010;
  localparam logic [10:0] X_LDB = 11'b01001000010;
  localparam logic [10:0] X_ADD = 11'b01000100010;
  localparam logic [10:0] X_WB  = 11'b00100000010;
  localparam logic [10:0] X_NOP = 11'b01000000010;
  localparam logic [10:0] X_EH  = 11'b00000000010;
  localparam logic [10:0] X_H   = 11'b00000000001;

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic fill_rom(input logic [3:0] op);
    for (int i = 0; i < 16; i++) rom[i] = op;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic run_one(input logic [3:0] op, input logic sp,
                         input logic co);
    fill_rom(OP_NOP);
    rom[0] = op;
    rom[1] = OP_HALT;
    StopProgram = sp;
    cout = co;
    do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_chk++;
    if (obs !== 11'b0) $display("FAIL reset_out got %b exp %b", obs, 11'b0);
    else n_pass++;
    n_chk++;
    if ({Timeout, Timeout_5, obs5} !== 13'b0)
      $display("FAIL reset_to got %b exp 0", {Timeout, Timeout_5, obs5});
    else n_pass++;
  endtask

  task automatic test_reset_in_exec();
    run_one(OP_ADD, 1'b0, 1'b0);
    n_chk++;
    if (ANSload !== 1'b1) $display("FAIL rst_exec_pre got %b exp 1", ANSload);
    else n_pass++;
    Reset = 1'b1;
    Start = 1'b1;
    step();
    step();
    Reset = 1'b0;
    Start = 1'b0;
    step();
    n_chk++;
    if ({obs, Timeout} !== 12'b0)
      $display("FAIL rst_exec got %b exp 0", {obs, Timeout});
    else n_pass++;
  endtask

  task automatic test_program();
    logic [10:0] exp_seq [14];
    exp_seq = '{X_F, X_L, X_LDA, X_F, X_L, X_LDB, X_F, X_L,
                X_ADD, X_WB, X_F, X_L, X_EH, X_H};
    fill_rom(OP_NOP);
    rom[0] = OP_LDA; rom[1] = OP_LDB; rom[2] = OP_ADD; rom[3] = OP_HALT;
    do_reset();
    Start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      Start = 1'b0;
      n_chk++;
      if (obs !== exp_seq[c-1])
        $display("FAIL prog_c%0d got %b exp %b", c, obs, exp_seq[c-1]);
      else n_pass++;
    end
  endtask

  task automatic test_alu_modes();
    logic [3:0] ops [3];
    logic [1:0] md  [3];
    ops = '{OP_SUB, OP_AND, OP_OR};
    md  = '{ALU_SUB, ALU_AND, ALU_OR};
    for (int k = 0; k < 3; k++) begin
      run_one(ops[k], 1'b0, 1'b0);
      n_chk++;
      if ({ANSload, SelectMode} !== {1'b1, md[k]})
        $display("FAIL alu_ex%0d got %b exp %b", k,
                 {ANSload, SelectMode}, {1'b1, md[k]});
      else n_pass++;
      step();
      n_chk++;
      if ({Aload, A_select, SelectMode} !== {2'b10, md[k]})
        $display("FAIL alu_wb%0d got %b exp %b", k,
                 {Aload, A_select, SelectMode}, {2'b10, md[k]});
      else n_pass++;
    end
  endtask

  task automatic test_jumps();
    logic [3:0] ops [6];
    logic       sp  [6];
    logic       co  [6];
    logic       ej  [6];
    ops = '{OP_JLT, OP_JLT, OP_JC, OP_JC, 4'b1100, OP_JMP};
    sp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    co  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    ej  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      run_one(ops[k], sp[k], co[k]);
      n_chk++;
      if (obs !== (X_NOP | {6'b0, ej[k], 4'b0}))
        $display("FAIL jump%0d got %b exp %b", k, obs,
                 X_NOP | {6'b0, ej[k], 4'b0});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    fill_rom(OP_JMP);
    do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 2; c <= 15; c++) step();
    n_chk++;
    if ({Busy_5, PCload_5, Timeout_5} !== 3'b110)
      $display("FAIL to_e5 got %b exp 110", {Busy_5, PCload_5, Timeout_5});
    else n_pass++;
    step();
    n_chk++;
    if ({Busy_5, Halted_5, Timeout_5} !== 3'b011)
      $display("FAIL to_halt got %b exp 011", {Busy_5, Halted_5, Timeout_5});
    else n_pass++;
    Start = 1'b1;
    step();
    Start = 1'b0;
    n_chk++;
    if ({Busy_5, Halted_5, Timeout_5} !== 3'b100)
      $display("FAIL to_restart got %b exp 100",
               {Busy_5, Halted_5, Timeout_5});
    else n_pass++;
    for (int c = 18; c <= 31; c++) step();
    n_chk++;
    if ({Halted_5, Timeout_5} !== 2'b00)
      $display("FAIL to_wdclr got %b exp 00", {Halted_5, Timeout_5});
    else n_pass++;
    step();
    n_chk++;
    if ({Halted_5, Timeout_5} !== 2'b11)
      $display("FAIL to_again got %b exp 11", {Halted_5, Timeout_5});
    else n_pass++;
    do_reset();
    step();
    n_chk++;
    if ({Halted_5, Timeout_5} !== 2'b00)
      $display("FAIL to_reset got %b exp 00", {Halted_5, Timeout_5});
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    logic [10:0] exp_seq [7];
    exp_seq = '{X_F, X_L, X_NOP, X_F, X_L, X_EH, X_H};
    fill_rom(OP_NOP);
    rom[1] = OP_HALT;
    do_reset();
    Start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      n_chk++;
      if (obs !== exp_seq[c-1])
        $display("FAIL busy_c%0d got %b exp %b", c, obs, exp_seq[c-1]);
      else n_pass++;
    end
    Start = 1'b0;
  endtask

  task automatic test_alu_at_limit();
    fill_rom(OP_NOP);
    rom[4] = OP_ADD;
    rom[5] = OP_HALT;
    do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 2; c <= 15; c++) step();
    n_chk++;
    if (obs5 !== X_ADD)
      $display("FAIL lim_exec got %b exp %b", obs5, X_ADD);
    else n_pass++;
    step();
    n_chk++;
    if ({obs5, Timeout_5} !== {X_H, 1'b1})
      $display("FAIL lim_halt got %b exp %b", {obs5, Timeout_5},
               {X_H, 1'b1});
    else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    StopProgram = 1'b0;
    cout = 1'b0;
    fill_rom(OP_NOP);
    test_reset();
    test_reset_in_exec();
    test_program();
    test_alu_modes();
    test_jumps();
    test_timeout();
    test_start_while_busy();
    test_alu_at_limit();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
